// File: rtl/fp_mac_pkg.sv
// Shared definitions for the pipelined floating-point multiply-accumulate lane:
// default field widths, bias/limit helpers, field slicing and the run-control states.
package fp_mac_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Slices operate on a word right-justified in 64 bits so any lane width fits.
    function automatic logic fld_sign(input logic [63:0] word, input int w);
        return word[w-1];
    endfunction

    function automatic logic [63:0] fld_exp(input logic [63:0] word, input int man_w, input int exp_w);
        return (word >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic [63:0] fld_man(input logic [63:0] word, input int man_w);
        return word & ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_align_add.sv
// Combinational add of two unpacked floating-point values: align by exponent,
// add/subtract magnitudes exactly, renormalise, truncate, saturate or flush.
module fp_align_add
    import fp_mac_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic             a_sign_i,
    input  logic [EXP_W-1:0] a_exp_i,
    input  logic [MAN_W:0]   a_man_i,
    input  logic             a_zero_i,
    input  logic             b_sign_i,
    input  logic [EXP_W-1:0] b_exp_i,
    input  logic [MAN_W:0]   b_man_i,
    input  logic             b_zero_i,
    output logic [W-1:0]     sum_o
);
    localparam int SW   = 2*MAN_W + 3;
    localparam int EMAX = fp_exp_max(EXP_W);

    logic             a_big;
    logic             big_sign, small_sign;
    logic [EXP_W-1:0] big_exp, small_exp, diff;
    logic [MAN_W:0]   big_man, small_man;
    logic [SW-1:0]    big_ext, small_ext, mag;
    logic [MAN_W-1:0] frac;
    int               lead;
    int               res_exp;

    always_comb begin
        a_big      = {a_exp_i, a_man_i} >= {b_exp_i, b_man_i};
        big_sign   = a_big ? a_sign_i : b_sign_i;
        big_exp    = a_big ? a_exp_i  : b_exp_i;
        big_man    = a_big ? a_man_i  : b_man_i;
        small_sign = a_big ? b_sign_i : a_sign_i;
        small_exp  = a_big ? b_exp_i  : a_exp_i;
        small_man  = a_big ? b_man_i  : a_man_i;
        diff       = big_exp - small_exp;

        // Extra MAN_W+1 low bits keep the aligned sum exact before truncation.
        big_ext   = {1'b0, big_man, {(MAN_W+1){1'b0}}};
        small_ext = {1'b0, small_man, {(MAN_W+1){1'b0}}} >> diff;
        mag       = (big_sign != small_sign) ? big_ext - small_ext : big_ext + small_ext;

        lead = 0;
        for (int i = 0; i < SW; i++) begin
            if (mag[i]) lead = i;
        end
        frac    = MAN_W'((mag << (SW - 1 - lead)) >> (MAN_W + 2));
        res_exp = int'(big_exp) + lead - (2*MAN_W + 1);

        sum_o = '0;
        if (a_zero_i && b_zero_i)
            sum_o = '0;
        else if (a_zero_i)
            sum_o = {b_sign_i, b_exp_i, b_man_i[MAN_W-1:0]};
        else if (b_zero_i)
            sum_o = {a_sign_i, a_exp_i, a_man_i[MAN_W-1:0]};
        else if (int'(diff) >= MAN_W + 2)
            sum_o = {big_sign, big_exp, big_man[MAN_W-1:0]};
        else if (mag == '0)
            sum_o = '0;
        else if (res_exp > EMAX)
            sum_o = {big_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (res_exp < 1)
            sum_o = '0;
        else
            sum_o = {big_sign, EXP_W'(res_exp), frac};
    end

endmodule

// File: rtl/fp_mac_pipe.sv
// Handshaked floating-point multiply-accumulate lane: accumulates sum(a*b) over a
// run closed by in_last and presents one truncated result per run.
module fp_mac_pipe
    import fp_mac_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         Asynch_Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         busy
);
    localparam int BIAS = fp_bias(EXP_W);
    localparam int EMAX = fp_exp_max(EXP_W);
    localparam int PW   = 2*MAN_W + 2;
    localparam int XW   = EXP_W + 2;

    state_e state_q, state_d;
    logic   in_fire, out_fire;

    logic [W-1:0]         a_p1_q, b_p1_q;
    logic                 vld_p1_q, last_p1_q;
    logic [EXP_W-1:0]     ea_p1, eb_p1;
    logic [MAN_W:0]       ma_p1, mb_p1;

    logic [MAN_W+1:0]     prod_p2_q;
    logic signed [XW-1:0] exp_p2_q;
    logic                 sign_p2_q, zero_p2_q, vld_p2_q, last_p2_q;

    logic [MAN_W:0]       pman_p3;
    int                   pexp_p3;
    logic                 psign_p3, pzero_p3;
    logic [EXP_W-1:0]     acc_exp;
    logic [W-1:0]         acc_q, sum_w, out_result_q;
    logic                 last_p3_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // ---- S1: operand registers
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_p1_q    <= in_a;
            b_p1_q    <= in_b;
            last_p1_q <= in_last;
        end
    end

    always_comb begin
        ea_p1 = EXP_W'(fld_exp(64'(a_p1_q), MAN_W, EXP_W));
        eb_p1 = EXP_W'(fld_exp(64'(b_p1_q), MAN_W, EXP_W));
        ma_p1 = {1'b1, MAN_W'(fld_man(64'(a_p1_q), MAN_W))};
        mb_p1 = {1'b1, MAN_W'(fld_man(64'(b_p1_q), MAN_W))};
    end

    // ---- S2: product, sign, unnormalised exponent (only the top MAN_W+2 product bits survive truncation)
    always_ff @(posedge clk) begin
        prod_p2_q <= (MAN_W+2)'((PW'(ma_p1) * PW'(mb_p1)) >> MAN_W);
        exp_p2_q  <= XW'(int'(ea_p1) + int'(eb_p1) - BIAS);
        sign_p2_q <= fld_sign(64'(a_p1_q), W) ^ fld_sign(64'(b_p1_q), W);
        zero_p2_q <= (ea_p1 == '0) || (eb_p1 == '0);
        last_p2_q <= last_p1_q;
    end

    // ---- S3: normalise product, add into accumulator
    always_comb begin
        psign_p3 = sign_p2_q;
        pzero_p3 = zero_p2_q;
        if (prod_p2_q[MAN_W+1]) begin
            pman_p3 = prod_p2_q[MAN_W+1:1];
            pexp_p3 = int'(exp_p2_q) + 1;
        end else begin
            pman_p3 = prod_p2_q[MAN_W:0];
            pexp_p3 = int'(exp_p2_q);
        end
        if (!pzero_p3 && pexp_p3 > EMAX) begin
            pman_p3 = {1'b1, {MAN_W{1'b0}}};
            pexp_p3 = EMAX;
        end else if (!pzero_p3 && pexp_p3 < 1) begin
            pzero_p3 = 1'b1;
            psign_p3 = 1'b0;
        end
        acc_exp = EXP_W'(fld_exp(64'(acc_q), MAN_W, EXP_W));
    end

    fp_align_add #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_add (
        .a_sign_i (psign_p3),
        .a_exp_i  (EXP_W'(pexp_p3)),
        .a_man_i  (pman_p3),
        .a_zero_i (pzero_p3),
        .b_sign_i (fld_sign(64'(acc_q), W)),
        .b_exp_i  (acc_exp),
        .b_man_i  ({1'b1, MAN_W'(fld_man(64'(acc_q), MAN_W))}),
        .b_zero_i (acc_exp == '0),
        .sum_o    (sum_w)
    );

    always_ff @(posedge clk) begin
        if (Asynch_Reset || out_fire)
            acc_q <= '0;
        else if (vld_p2_q)
            acc_q <= sum_w;
    end

    // ---- Result register: captured the cycle after the last term lands in the accumulator
    always_ff @(posedge clk) begin
        if (Asynch_Reset)
            out_result_q <= '0;
        else if (state_q == DRAIN && last_p3_q)
            out_result_q <= acc_q;
    end

    always_ff @(posedge clk) begin
        if (Asynch_Reset) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p3_q <= 1'b0;
        end else begin
            vld_p1_q  <= in_fire;
            vld_p2_q  <= vld_p1_q;
            last_p3_q <= vld_p2_q & last_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (Asynch_Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = in_last ? DRAIN : ACCUM;
            ACCUM:   if (in_fire && in_last) state_d = DRAIN;
            DRAIN:   if (last_p3_q) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    assign out_result = out_result_q;

endmodule

// File: tb/tb_fp_mac_pipe.sv
// Bench for fp_mac_pipe: directed runs, randomised runs against a real-valued
// reference model, backpressure, mid-run reset and a single-precision lane.
module tb_fp_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_last, out_ready;
    logic [15:0] in_a, in_b;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_result;

    logic        v8_valid, v8_last, v8_out_ready;
    logic [31:0] v8_a, v8_b;
    logic        v8_in_ready, v8_out_valid, v8_busy;
    logic [31:0] v8_result;

    int checks   = 0;
    int failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    fp_mac_pipe dut (
        .clk(clk), .Asynch_Reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
    );

    fp_mac_pipe #(.EXP_W(8), .MAN_W(23)) dut8 (
        .clk(clk), .Asynch_Reset(rst),
        .in_valid(v8_valid), .in_ready(v8_in_ready), .in_a(v8_a), .in_b(v8_b), .in_last(v8_last),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_result(v8_result), .busy(v8_busy)
    );

    // ---------------- reference model (half precision, real arithmetic)
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real to_real(input logic [15:0] w);
        real v;
        if (w[14:10] == 5'd0) return 0.0;
        v = (1.0 + real'(w[9:0]) / 1024.0) * pow2(int'(w[14:10]) - 15);
        return w[15] ? -v : v;
    endfunction

    // Truncate toward zero to 11 significant bits, then saturate or flush.
    function automatic logic [15:0] from_real(input real x);
        real y;
        int  e, m, be;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        y = s ? -x : x;
        e = 0;
        while (y >= 2.0) begin y = y / 2.0; e++; end
        while (y < 1.0)  begin y = y * 2.0; e--; end
        m  = int'($floor(y * 1024.0));
        be = e + 15;
        if (be > 31) return {s, 5'h1f, 10'h000};
        if (be < 1)  return 16'h0000;
        return {s, 5'(be), 10'(m - 1024)};
    endfunction

    function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
        int d;
        if (y[14:10] == 5'd0) return (x[14:10] == 5'd0) ? 16'h0000 : x;
        if (x[14:10] == 5'd0) return y;
        d = int'(x[14:10]) - int'(y[14:10]);
        if (d < 0) d = -d;
        if (d >= 12) return (rabs(to_real(x)) > rabs(to_real(y))) ? x : y;
        return from_real(to_real(x) + to_real(y));
    endfunction

    function automatic logic [15:0] model_run();
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < qa.size(); i++)
            acc = model_add(acc, from_real(to_real(qa[i]) * to_real(qb[i])));
        return acc;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] w;
        int k;
        w = 16'($urandom);
        k = $urandom_range(0, 15);
        if (k == 0)      w[14:10] = 5'd0;
        else if (k == 1) w[14:10] = 5'(29 + $urandom_range(0, 2));
        else             w[14:10] = 5'($urandom_range(11, 19));
        return w;
    endfunction

    // ---------------- driver: streams qa/qb back to back, then collects the result
    task automatic do_run(input int hold, output logic [15:0] res, output int lat,
                          output bit rdy_low, output bit stable);
        int guard;
        rdy_low = 1'b1;
        stable  = 1'b1;
        for (int i = 0; i < qa.size(); i++) begin
            guard = 0;
            while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
            in_valid = 1'b1;
            in_a     = qa[i];
            in_b     = qb[i];
            in_last  = (i == qa.size() - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = out_result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_result !== res || !out_valid || in_ready) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL reset_out_result got=%h want=0000", out_result); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_run();
        logic [15:0] res; int lat; bit rl, st;
        qa = '{16'h3C00, 16'h4000};
        qb = '{16'h4000, 16'h4200};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h4800) begin failures++; $display("FAIL basic_result got=%h want=4800", res); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d want=4", lat); end
        checks++; if (rl !== 1'b1) begin failures++; $display("FAIL basic_in_ready_low got=%b want=1", rl); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_after_handshake got ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] res; int lat; bit rl, st;
        qa = '{16'h3E00}; qb = '{16'h3E00};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h4080) begin failures++; $display("FAIL single_term got=%h want=4080", res); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL single_latency got=%0d want=4", lat); end
        qa = '{16'h4000, 16'hC000}; qb = '{16'h4200, 16'h4200};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h0000) begin failures++; $display("FAIL cancellation got=%h want=0000", res); end
        qa = '{16'h7BFF}; qb = '{16'h7BFF};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h7C00) begin failures++; $display("FAIL saturate got=%h want=7C00", res); end
        qa = '{16'h0001}; qb = '{16'h3C00};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h0000) begin failures++; $display("FAIL subnormal_flush got=%h want=0000", res); end
    endtask

    task automatic test_backpressure();
        logic [15:0] res; int lat; bit rl, st;
        qa = '{16'h4000}; qb = '{16'h4200};
        do_run(5, res, lat, rl, st);
        checks++; if (res !== 16'h4600) begin failures++; $display("FAIL bp_result got=%h want=4600", res); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL bp_hold_stable got=%b want=1", st); end
        qa = '{16'h3C00}; qb = '{16'h3C00};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h3C00) begin failures++; $display("FAIL bp_next_run got=%h want=3C00", res); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] res; int lat; bit rl, st;
        in_valid = 1'b1; in_last = 1'b0; in_a = 16'h4000; in_b = 16'h4200;
        @(negedge clk);
        in_a = 16'h4400; in_b = 16'h4400;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0000 || busy !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got ready=%b valid=%b result=%h busy=%b want 1/0/0000/0", in_ready, out_valid, out_result, busy);
        end
        qa = '{16'h3C00}; qb = '{16'h4000};
        do_run(0, res, lat, rl, st);
        checks++; if (res !== 16'h4000) begin failures++; $display("FAIL midrst_new_run got=%h want=4000", res); end
    endtask

    task automatic test_random();
        logic [15:0] res, want; int lat; bit rl, st; int n;
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 6);
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(rand_op());
                qb.push_back(rand_op());
            end
            want = model_run();
            do_run($urandom_range(0, 2), res, lat, rl, st);
            checks++; if (res !== want) begin failures++; $display("FAIL random_run%0d got=%h want=%h terms=%0d", r, res, want, n); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL random_latency%0d got=%0d want=4", r, lat); end
        end
    endtask

    task automatic test_param_variant();
        logic [31:0] av[2] = '{32'h3F800000, 32'h40400000};
        logic [31:0] bv[2] = '{32'h40000000, 32'h40400000};
        logic [31:0] wv[2] = '{32'h40000000, 32'h41100000};
        int lat;
        for (int k = 0; k < 2; k++) begin
            v8_valid = 1'b1; v8_last = 1'b1; v8_a = av[k]; v8_b = bv[k];
            @(negedge clk);
            v8_valid = 1'b0; v8_last = 1'b0;
            lat = 1;
            while (!v8_out_valid && lat < 40) begin @(negedge clk); lat++; end
            checks++; if (v8_result !== wv[k]) begin failures++; $display("FAIL sp_result%0d got=%h want=%h", k, v8_result, wv[k]); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL sp_latency%0d got=%0d want=4", k, lat); end
            v8_out_ready = 1'b1;
            @(negedge clk);
            v8_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        v8_valid = 1'b0; v8_last = 1'b0; v8_out_ready = 1'b0; v8_a = '0; v8_b = '0;
        test_reset();
        test_basic_run();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_param_variant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
